// File: rtl/based_literal_parser.sv
`timescale 1ns/1ps
// Streaming parser for VHDL-style abstract literals (decimal and base#digits#).
// Ports: sysclk/reset; in_valid/in_data/in_ready char input;
// out_valid/out_ready handshake with out_value, out_base, out_ovf, out_err.
module based_literal_parser (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_value,
  output logic [4:0]  out_base,
  output logic        out_ovf,
  output logic        out_err
);

  typedef enum logic [2:0] {
    IDLE, INT, BASED, CLOSED, SKIP
  } state_t;

  state_t      state, state_n;
  logic [31:0] acc, acc_n;
  logic [4:0]  radix, radix_n;
  logic        ovf, ovf_n;
  logic        us, us_n;
  logic        dseen, dseen_n;

  logic        emit, emit_err, emit_ovf;
  logic [31:0] emit_value;
  logic [4:0]  emit_base;

  logic        take;
  logic        is_term, is_hash, is_us;
  logic        is_dig, is_dec, in_radix;
  logic [3:0]  dval;
  logic [4:0]  mult;
  logic [36:0] mac;

  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready;

  assign is_term = (in_data == 8'h20) ||
                   (in_data == 8'h0A) ||
                   (in_data == 8'h3B);
  assign is_hash = (in_data == 8'h23);
  assign is_us   = (in_data == 8'h5F);

  // Letters a-f/A-F share low nibbles 1..6, so +9 maps them to 10..15.
  always_comb begin
    is_dig = 1'b0;
    dval   = 4'd0;
    if (in_data >= 8'h30 && in_data <= 8'h39) begin
      is_dig = 1'b1;
      dval   = in_data[3:0];
    end else if ((in_data >= 8'h61 && in_data <= 8'h66) ||
                 (in_data >= 8'h41 && in_data <= 8'h46)) begin
      is_dig = 1'b1;
      dval   = in_data[3:0] + 4'd9;
    end
  end

  assign is_dec   = is_dig && (dval < 4'd10);
  assign in_radix = is_dig && ({1'b0, dval} < radix);

  // Wide multiply-add so anything past bit 31 is visible for overflow.
  assign mult = (state == INT) ? 5'd10 : radix;
  assign mac  = {5'd0, acc} * {32'd0, mult} + {33'd0, dval};

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    radix_n    = radix;
    ovf_n      = ovf;
    us_n       = us;
    dseen_n    = dseen;
    emit       = 1'b0;
    emit_err   = 1'b0;
    emit_value = 32'd0;
    emit_base  = 5'd0;
    emit_ovf   = 1'b0;

    if (take) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            is_term: ;
            is_dec: begin
              state_n = INT;
              acc_n   = {28'd0, dval};
            end
            default: state_n = SKIP;
          endcase
        end

        INT: begin
          unique case (1'b1)
            is_dec: begin
              acc_n = mac[31:0];
              ovf_n = ovf | (|mac[36:32]);
              us_n  = 1'b0;
            end
            is_us: begin
              if (us) state_n = SKIP;
              else    us_n    = 1'b1;
            end
            is_hash: begin
              // A base that overflowed is out of range, whatever its low bits.
              if (!us && !ovf && acc >= 32'd2 && acc <= 32'd16) begin
                state_n = BASED;
                radix_n = acc[4:0];
                acc_n   = 32'd0;
                ovf_n   = 1'b0;
                us_n    = 1'b0;
                dseen_n = 1'b0;
              end else begin
                state_n = SKIP;
              end
            end
            is_term: begin
              emit = 1'b1;
              if (us) begin
                emit_err = 1'b1;
              end else begin
                emit_value = acc;
                emit_base  = 5'd10;
                emit_ovf   = ovf;
              end
            end
            default: state_n = SKIP;
          endcase
        end

        BASED: begin
          unique case (1'b1)
            in_radix: begin
              acc_n   = mac[31:0];
              ovf_n   = ovf | (|mac[36:32]);
              us_n    = 1'b0;
              dseen_n = 1'b1;
            end
            is_us: begin
              if (us || !dseen) state_n = SKIP;
              else              us_n    = 1'b1;
            end
            is_hash: begin
              if (dseen && !us) state_n = CLOSED;
              else              state_n = SKIP;
            end
            is_term: begin
              emit     = 1'b1;
              emit_err = 1'b1;
            end
            default: state_n = SKIP;
          endcase
        end

        CLOSED: begin
          if (is_term) begin
            emit       = 1'b1;
            emit_value = acc;
            emit_base  = radix;
            emit_ovf   = ovf;
          end else begin
            state_n = SKIP;
          end
        end

        SKIP: begin
          if (is_term) begin
            emit     = 1'b1;
            emit_err = 1'b1;
          end
        end

        default: state_n = IDLE;
      endcase

      if (is_term) begin
        state_n = IDLE;
        acc_n   = 32'd0;
        radix_n = 5'd0;
        ovf_n   = 1'b0;
        us_n    = 1'b0;
        dseen_n = 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= 32'd0;
      radix <= 5'd0;
      ovf   <= 1'b0;
      us    <= 1'b0;
      dseen <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      radix <= radix_n;
      ovf   <= ovf_n;
      us    <= us_n;
      dseen <= dseen_n;
    end
  end

  // Emit only happens on a take, so the old result is gone or leaving.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_value <= 32'd0;
      out_base  <= 5'd0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_value <= emit_value;
      out_base  <= emit_base;
      out_ovf   <= emit_ovf;
      out_err   <= emit_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
